// File: rtl/shift_defs_pkg.sv
// Shared definitions for the shift/rotate execution path: operand width, op encodings and
// the bit-reverse helper used to turn left operations into right ones.
package shift_defs;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned AMT_W  = 4;
   localparam int unsigned OP_W   = 3;

   typedef enum logic [OP_W-1:0] {
      OpRol = 3'b000,
      OpSll = 3'b001,
      OpRor = 3'b010,
      OpSrl = 3'b011,
      OpSra = 3'b100
   } shift_op_e;

   function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] x);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < int'(DATA_W); i++) begin
         r[i] = x[int'(DATA_W) - 1 - i];
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_rotate_right.sv
// Right rotate / right logical shift of one operand by a variable amount.
module shift_rotate_right #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned AMT_W  = 4
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic [AMT_W-1:0]  amt_i,
   input  logic              rotate_i,
   output logic [DATA_W-1:0] result_o
);

   logic [2*DATA_W-1:0] rot_wide;

   always_comb begin
      // The low half of the doubled operand shifted right is the rotate result.
      rot_wide = {data_i, data_i} >> amt_i;
      if (rotate_i) begin
         result_o = rot_wide[DATA_W-1:0];
      end else begin
         result_o = data_i >> amt_i;
      end
   end

endmodule

// File: rtl/shift_exec_pipe.sv
// Two-stage shift/rotate execution pipe: S1 holds the request, S2 holds the computed result.
// Left ops reuse the right-shift datapath by bit-reversing the operand and the result.
module shift_exec_pipe #(
   parameter int unsigned DATA_W = shift_defs::DATA_W,
   parameter int unsigned TAG_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [3:0]        in_amt,
   input  logic [2:0]        in_op,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err
);

   import shift_defs::*;

   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_data_q, s1_data_d;
   logic [3:0]        s1_amt_q, s1_amt_d;
   logic [2:0]        s1_op_q, s1_op_d;
   logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] s2_data_q, s2_data_d;
   logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
   logic              s2_err_q, s2_err_d;

   logic              s2_free, s1_adv, accept, out_fire;
   logic              left_op, rotate_op;
   logic [DATA_W-1:0] sr_in, sr_out, result;
   logic              result_err;

   always_comb begin
      out_fire = s2_valid_q & out_ready;
      s2_free  = ~s2_valid_q | out_ready;
      s1_adv   = s1_valid_q & s2_free;
      in_ready = rst_n & ~flush & (~s1_valid_q | s1_adv);
      accept   = in_valid & in_ready;
   end

   always_comb begin
      left_op   = (s1_op_q == OpRol) || (s1_op_q == OpSll);
      rotate_op = (s1_op_q == OpRol) || (s1_op_q == OpRor);
      sr_in     = left_op ? bit_rev(s1_data_q) : s1_data_q;
   end

   shift_rotate_right #(
      .DATA_W (DATA_W),
      .AMT_W  (4)
   ) u_shift_rotate_right (
      .data_i   (sr_in),
      .amt_i    (s1_amt_q),
      .rotate_i (rotate_op),
      .result_o (sr_out)
   );

   always_comb begin
      result     = sr_out;
      result_err = 1'b0;
      case (s1_op_q)
         OpRol, OpSll: result = bit_rev(sr_out);
         OpRor, OpSrl: result = sr_out;
         // Fill the top amt bits with the sign of the operand.
         OpSra: result = sr_out |
                         (~({DATA_W{1'b1}} >> s1_amt_q) & {DATA_W{s1_data_q[DATA_W-1]}});
         default: begin
            result     = s1_data_q;
            result_err = 1'b1;
         end
      endcase
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_amt_d   = s1_amt_q;
      s1_op_d    = s1_op_q;
      s1_tag_d   = s1_tag_q;
      if (flush) begin
         s1_valid_d = 1'b0;
      end else if (accept) begin
         s1_valid_d = 1'b1;
         s1_data_d  = in_data;
         s1_amt_d   = in_amt;
         s1_op_d    = in_op;
         s1_tag_d   = in_tag;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_tag_d   = s2_tag_q;
      s2_err_d   = s2_err_q;
      if (flush) begin
         s2_valid_d = 1'b0;
      end else if (s1_adv) begin
         s2_valid_d = 1'b1;
         s2_data_d  = result;
         s2_tag_d   = s1_tag_q;
         s2_err_d   = result_err;
      end else if (out_fire) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_amt_q   <= '0;
         s1_op_q    <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_tag_q   <= '0;
         s2_err_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_amt_q   <= s1_amt_d;
         s1_op_q    <= s1_op_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_tag_q   <= s2_tag_d;
         s2_err_q   <= s2_err_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_tag   = s2_tag_q;
   assign out_err   = s2_err_q;

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Bench for shift_exec_pipe: directed cases plus random traffic scored against a queue model.
module tb_shift_exec_pipe;

   localparam int unsigned TAG_W = 3;

   logic              clk = 1'b0;
   logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_err;
   logic [15:0]       in_data, out_data;
   logic [3:0]        in_amt;
   logic [2:0]        in_op;
   logic [TAG_W-1:0]  in_tag, out_tag;

   always #5 clk = ~clk;

   shift_exec_pipe #(
      .DATA_W (16),
      .TAG_W  (TAG_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_op     (in_op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_err   (out_err)
   );

   typedef struct packed {
      logic [15:0]      data;
      logic [TAG_W-1:0] tag;
      logic             err;
   } res_t;

   res_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
      end
   endtask

   // Reference: shifts and rotates computed directly with wide arithmetic.
   function automatic res_t model(input logic [15:0] d, input logic [3:0] a,
                                  input logic [2:0] op, input logic [TAG_W-1:0] t);
      logic [31:0]        wide;
      logic signed [15:0] sd;
      res_t               r;
      r.tag = t;
      r.err = 1'b0;
      wide  = {d, d};
      sd    = d;
      case (op)
         3'd0: begin wide = wide << a; r.data = wide[31:16]; end
         3'd1: r.data = d << a;
         3'd2: begin wide = wide >> a; r.data = wide[15:0]; end
         3'd3: r.data = d >> a;
         3'd4: r.data = sd >>> a;
         default: begin r.data = d; r.err = 1'b1; end
      endcase
      return r;
   endfunction

   // One clock from negedge to negedge: score any consume, then track accepts and flushes.
   task automatic step(output logic acc);
      logic cons, fl;
      res_t req, exp;
      #1;
      acc  = in_valid & in_ready;
      cons = out_valid & out_ready;
      fl   = flush;
      req  = model(in_data, in_amt, in_op, in_tag);
      if (cons) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", {31'd0, out_valid}, 32'd0);
         end else begin
            exp = exp_q[0];
            check("out_data", {16'd0, out_data}, {16'd0, exp.data});
            check("out_tag", {29'd0, out_tag}, {29'd0, exp.tag});
            check("out_err", {31'd0, out_err}, {31'd0, exp.err});
         end
      end
      if (fl) check("in_ready_flush", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      if (cons && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(req);
      if (fl) exp_q.delete();
      @(negedge clk);
   endtask

   task automatic drain();
      logic a;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 8 && exp_q.size() > 0; i++) step(a);
      check("drain_pending", exp_q.size(), 32'd0);
      check("drain_idle", {31'd0, out_valid}, 32'd0);
   endtask

   task automatic directed(input string name, input logic [15:0] d, input logic [3:0] a,
                           input logic [2:0] op, input logic [15:0] exp_d, input logic exp_e);
      logic acc;
      in_valid  = 1'b1;
      in_data   = d;
      in_amt    = a;
      in_op     = op;
      in_tag    = 3'd5;
      out_ready = 1'b1;
      step(acc);
      check({name, "_accept"}, {31'd0, acc}, 32'd1);
      in_valid = 1'b0;
      check({name, "_not_yet"}, {31'd0, out_valid}, 32'd0);
      step(acc);
      check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({name, "_data"}, {16'd0, out_data}, {16'd0, exp_d});
      check({name, "_err"}, {31'd0, out_err}, {31'd0, exp_e});
      step(acc);
   endtask

   task automatic fill_two();
      logic acc;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 16'($urandom);
         in_amt  = 4'($urandom);
         in_op   = 3'($urandom_range(0, 4));
         in_tag  = 3'(i);
         step(acc);
         check("fill_accept", {31'd0, acc}, (i < 2) ? 32'd1 : 32'd0);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      logic        acc;
      logic [15:0] hold_data;
      logic [2:0]  hold_tag;
      logic [15:0] r;

      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = 16'hffff;
      in_amt    = 4'd3;
      in_op     = 3'd1;
      in_tag    = 3'd7;
      repeat (3) @(negedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {16'd0, out_data}, 32'd0);
      check("rst_out_tag", {29'd0, out_tag}, 32'd0);
      check("rst_out_err", {31'd0, out_err}, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      #1;
      check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
      @(negedge clk);

      directed("rol", 16'h8001, 4'd1, 3'b000, 16'h0003, 1'b0);
      directed("sra", 16'h8000, 4'd4, 3'b100, 16'hF800, 1'b0);
      directed("srl", 16'h8000, 4'd4, 3'b011, 16'h0800, 1'b0);
      directed("illegal", 16'h1234, 4'd5, 3'b110, 16'h1234, 1'b1);
      r = 16'($urandom);
      directed("amt0_sll", r, 4'd0, 3'b001, r, 1'b0);
      directed("amt0_sra", r, 4'd0, 3'b100, r, 1'b0);

      // Back-to-back with out_ready held high: one accept and one result every cycle.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 40; i++) begin
         in_data = 16'($urandom);
         in_amt  = 4'($urandom);
         in_op   = 3'($urandom_range(0, 7));
         in_tag  = 3'(i);
         if (i >= 2) check("b2b_out_valid", {31'd0, out_valid}, 32'd1);
         step(acc);
         check("b2b_accept", {31'd0, acc}, 32'd1);
      end
      drain();

      // Stall: two accepts fill the pipe, then the held result must not move.
      fill_two();
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      hold_data = out_data;
      hold_tag  = out_tag;
      step(acc);
      step(acc);
      check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
      check("stall_hold_data", {16'd0, out_data}, {16'd0, hold_data});
      check("stall_hold_tag", {29'd0, out_tag}, {29'd0, hold_tag});
      drain();

      // Random traffic with random backpressure.
      for (int i = 0; i < 300; i++) begin
         in_valid  = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = 16'($urandom);
         in_amt    = 4'($urandom);
         in_op     = 3'($urandom_range(0, 7));
         in_tag    = 3'($urandom);
         step(acc);
      end
      drain();

      // Flush with both stages full and a simultaneous consume.
      fill_two();
      flush     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      step(acc);
      check("flush_no_accept", {31'd0, acc}, 32'd0);
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_out_valid", {31'd0, out_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(acc);
         check("flush_no_stale", {31'd0, out_valid}, 32'd0);
      end

      // Reset asserted mid-operation.
      fill_two();
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      check("midrst_out_data", {16'd0, out_data}, 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(acc);
         check("midrst_no_stale", {31'd0, out_valid}, 32'd0);
      end
      directed("post_rst_ror", 16'h0001, 4'd1, 3'b010, 16'h8000, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_exec_pipe.md
SHIFT_EXEC_PIPE -- requirements
Module: shift_exec_pipe

Interface
REQ-001 The block SHALL have a parameter DATA_W, default 16, giving the operand width; only 16 is supported.
REQ-002 The block SHALL have a parameter TAG_W, default 3, giving the width of the destination-register tag.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous pipeline squash.
REQ-006 The block SHALL have port in_valid, input, 1 bit: request present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block accepts a request this cycle.
REQ-008 The block SHALL have port in_data, input, 16 bits: operand.
REQ-009 The block SHALL have port in_amt, input, 4 bits: shift/rotate amount, 0-15.
REQ-010 The block SHALL have port in_op, input, 3 bits: 000 ROL, 001 SLL, 010 ROR, 011 SRL, 100 SRA, 101-111 illegal.
REQ-011 The block SHALL have port in_tag, input, TAG_W bits: destination tag, passed through unchanged.
REQ-012 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-013 The block SHALL have port out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-014 The block SHALL have port out_data, output, 16 bits: result.
REQ-015 The block SHALL have port out_tag, output, TAG_W bits: tag of the result.
REQ-016 The block SHALL have port out_err, output, 1 bit: result came from an illegal op.

Function
REQ-017 A request SHALL be accepted on a cycle with in_valid and in_ready both high; an output SHALL be consumed on a cycle with out_valid and out_ready both high.
REQ-018 The pipeline SHALL have two register stages: S1 latches the request fields, S2 latches the computed result.
REQ-019 Latency SHALL be 2 cycles: a request accepted at edge N appears on out_* after edge N+1 when S2 is free.
REQ-020 Throughput SHALL be one request per cycle while out_ready is held high.
REQ-021 S2 SHALL load from S1 when S1 is valid and either S2 is empty or S2 is consumed in the same cycle.
REQ-022 in_ready SHALL equal not-S1-valid OR S1-advancing-this-cycle; this path SHALL be combinational from out_ready.
REQ-023 While out_valid is high and out_ready is low, out_data, out_tag and out_err SHALL hold stable.
REQ-024 ROR and SRL SHALL use right rotate and right logical shift of in_data by in_amt.
REQ-025 ROL and SLL SHALL be computed by bit-reversing the operand, applying the right rotate or logical shift, then bit-reversing the result.
REQ-026 SRA SHALL be the SRL result OR-ed with the top in_amt bits forced to in_data[15].
REQ-027 When in_amt is 0, out_data SHALL equal in_data for every legal op.
REQ-028 An illegal op SHALL pass in_data unchanged with out_err high and SHALL NOT stall the pipeline.
REQ-029 When flush is high at an edge, S1 valid and S2 valid SHALL both clear and no request SHALL be accepted on that edge; in_ready SHALL be low during flush.
REQ-030 When flush and a simultaneous output consume occur on the same edge, the consume SHALL count and the slot SHALL still clear.

Reset
REQ-031 On rst_n low, S1 valid and S2 valid SHALL be 0 immediately, without waiting for a clock edge.
REQ-032 While rst_n is low, out_valid SHALL be 0, out_data 0, out_tag 0 and out_err 0.
REQ-033 While rst_n is low, in_ready SHALL be 0, and in_ready SHALL become 1 on the first cycle after reset deasserts.
REQ-034 A reset asserted mid-operation SHALL discard all in-flight requests with no partial output.

Structure
REQ-035 The op encodings and DATA_W SHALL be defined in a shared package/include, shift_defs, used by decode and this block.
REQ-036 The right shift/rotate datapath SHALL reuse the existing shift_rotate_right sub-module, one instance, placed between S1 and S2.
REQ-037 The bit-reverse and SRA sign-fill logic SHALL be local combinational logic.

Verification
REQ-038 The bench SHALL check ROL: in_data=16'h8001, amt=1, op=000, giving out_data=16'h0003 two cycles after accept.
REQ-039 The bench SHALL check SRA: in_data=16'h8000, amt=4, op=100, giving 16'hF800; and SRL on the same operand giving 16'h0800.
REQ-040 The bench SHALL issue back-to-back requests with out_ready=1 and check one result per cycle with tags in order.
REQ-041 The bench SHALL fill the pipeline with out_ready=0 and check that in_ready drops after 2 accepts and that out_data holds stable; raising out_ready SHALL drain both results in order.
REQ-042 The bench SHALL issue op=110 with in_data=16'h1234 and check out_data=16'h1234 with out_err=1.
REQ-043 The bench SHALL apply flush, or rst_n low, with both stages full and check out_valid=0 on the next cycle (immediately for reset) and that no stale result appears afterwards.
